// File: rtl/mem_xlate_issue.sv
// Execute-side memory access unit: stage register, address translation, exception
// detection and SRAM-like bus issue with bounded outstanding requests.
// Optional TLB path enabled by defining MEM_XLATE_TLB_EN.
module mem_xlate_issue #(
    parameter int NUM_DMW     = 2,
    parameter int OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_allowin,
    input  logic                   in_load,
    input  logic                   in_store,
    input  logic [1:0]             in_size,
    input  logic [31:0]            in_vaddr,
    input  logic [31:0]            in_wdata,
    output logic                   out_valid,
    input  logic                   out_allowin,
    output logic [2:0]             out_exc,
    output logic [31:0]            out_vaddr,
    output logic                   out_mem_req,
    input  logic                   flush,
    input  logic [1:0]             crmd_plv,
    input  logic                   direct_addr,
    input  logic [3*NUM_DMW-1:0]   dmw_vseg,
    input  logic [3*NUM_DMW-1:0]   dmw_pseg,
    input  logic [NUM_DMW-1:0]     dmw_plv0,
    input  logic [NUM_DMW-1:0]     dmw_plv3,
    output logic [18:0]            tlb_vppn,
    output logic                   tlb_va_bit12,
    input  logic                   tlb_found,
    input  logic                   tlb_v,
    input  logic                   tlb_d,
    input  logic [19:0]            tlb_ppn,
    input  logic [5:0]             tlb_ps,
    input  logic [1:0]             tlb_plv,
    output logic                   data_req,
    output logic                   data_wr,
    output logic [1:0]             data_size,
    output logic [3:0]             data_wstrb,
    output logic [31:0]            data_addr,
    output logic [31:0]            data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    output logic                   data_ok_drop
);

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ALE  = 3'd1;
    localparam logic [2:0] EXC_ADEM = 3'd2;
`ifdef MEM_XLATE_TLB_EN
    localparam logic [2:0] EXC_TLBR = 3'd3;
    localparam logic [2:0] EXC_PIL  = 3'd4;
    localparam logic [2:0] EXC_PIS  = 3'd5;
    localparam logic [2:0] EXC_PPI  = 3'd6;
    localparam logic [2:0] EXC_PME  = 3'd7;
`endif
    localparam logic [2:0] OUT_MAX  = 3'(OUTSTANDING);

    // stage register
    logic        valid_q, valid_d;
    logic        load_q, load_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  drop_cnt_q, drop_cnt_d;

    logic              is_mem;
    logic [NUM_DMW-1:0] win_hit;
    logic              dmw_hit;
    logic [2:0]        pseg_sel;
    logic [31:0]       paddr;
    logic [2:0]        exc_raw;
    logic [2:0]        exc;
    logic [3:0]        wstrb;
    logic [31:0]       wdata_rep;
    logic              ready_go;
    logic              accept;
    logic              data_ret;

    assign is_mem = load_q | store_q;

    for (genvar g = 0; g < NUM_DMW; g++) begin : g_win
        assign win_hit[g] = (vaddr_q[31:29] == dmw_vseg[3*g +: 3]) &
                            (((crmd_plv == 2'd0) & dmw_plv0[g]) |
                             ((crmd_plv == 2'd3) & dmw_plv3[g]));
    end

    // lowest-index window wins: scan downward so the last hit assigned is the lowest
    always_comb begin
        dmw_hit  = 1'b0;
        pseg_sel = 3'd0;
        for (int i = NUM_DMW - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                dmw_hit  = 1'b1;
                pseg_sel = dmw_pseg[3*i +: 3];
            end
        end
    end

    always_comb begin
        paddr = vaddr_q;
        if (direct_addr) begin
            paddr = vaddr_q;
        end else if (dmw_hit) begin
            paddr = {pseg_sel, vaddr_q[28:0]};
        end else begin
`ifdef MEM_XLATE_TLB_EN
            if (tlb_ps == 6'd22) paddr = {tlb_ppn[19:10], vaddr_q[21:0]};
            else                 paddr = {tlb_ppn, vaddr_q[11:0]};
`else
            paddr = vaddr_q;
`endif
        end
    end

`ifdef MEM_XLATE_TLB_EN
    logic tlb_path;
    assign tlb_path     = !direct_addr & !dmw_hit;
    assign tlb_vppn     = vaddr_q[31:13];
    assign tlb_va_bit12 = vaddr_q[12];
`else
    logic unused_tlb;
    assign unused_tlb   = ^{tlb_found, tlb_v, tlb_d, tlb_ppn, tlb_ps, tlb_plv};
    assign tlb_vppn     = 19'd0;
    assign tlb_va_bit12 = 1'b0;
`endif

    always_comb begin
        exc_raw = EXC_NONE;
        if (((size_q == 2'd1) & vaddr_q[0]) | (size_q[1] & (vaddr_q[1:0] != 2'd0))) begin
            exc_raw = EXC_ALE;
        end else if (vaddr_q[31] & (crmd_plv == 2'd3) & !dmw_hit & !direct_addr) begin
            exc_raw = EXC_ADEM;
`ifdef MEM_XLATE_TLB_EN
        end else if (tlb_path & !tlb_found) begin
            exc_raw = EXC_TLBR;
        end else if (tlb_path & !tlb_v) begin
            exc_raw = load_q ? EXC_PIL : EXC_PIS;
        end else if (tlb_path & (crmd_plv > tlb_plv)) begin
            exc_raw = EXC_PPI;
        end else if (tlb_path & store_q & !tlb_d) begin
            exc_raw = EXC_PME;
`endif
        end
    end

    assign exc = (valid_q & is_mem) ? exc_raw : EXC_NONE;

    // store lanes: narrow data is replicated so the bus picks it up by strobe
    always_comb begin
        case (size_q)
            2'd0: begin
                wstrb     = 4'b0001 << vaddr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                wstrb     = vaddr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
        if (!store_q) wstrb = 4'b0000;
    end

    assign data_req   = valid_q & is_mem & (exc == EXC_NONE) & !flush & out_allowin &
                        (cnt_q < OUT_MAX);
    assign accept     = data_req & data_addr_ok;
    assign ready_go   = !is_mem | (exc != EXC_NONE) | accept;
    assign in_allowin = !valid_q | (ready_go & out_allowin);
    assign out_valid  = valid_q & ready_go;

    assign data_wr     = valid_q & store_q;
    assign data_size   = valid_q ? size_q : 2'd0;
    assign data_wstrb  = valid_q ? wstrb : 4'd0;
    assign data_addr   = valid_q ? paddr : 32'd0;
    assign data_wdata  = valid_q ? wdata_rep : 32'd0;
    assign out_exc     = exc;
    assign out_vaddr   = vaddr_q;
    assign out_mem_req = valid_q & is_mem & (exc == EXC_NONE);

    assign data_ret     = data_data_ok & (cnt_q != 3'd0);
    assign data_ok_drop = data_data_ok & (drop_cnt_q != 3'd0);

    always_comb begin
        valid_d = valid_q;
        load_d  = load_q;
        store_d = store_q;
        size_d  = size_q;
        vaddr_d = vaddr_q;
        wdata_d = wdata_q;
        if (in_valid & in_allowin) begin
            load_d  = in_load;
            store_d = in_store;
            size_d  = in_size;
            vaddr_d = in_vaddr;
            wdata_d = in_wdata;
        end
        if (flush)                       valid_d = 1'b0;
        else if (in_valid & in_allowin)  valid_d = 1'b1;
        else if (out_valid & out_allowin) valid_d = 1'b0;
    end

    // req is masked during flush, so cnt_d there already excludes any new accept
    always_comb begin
        cnt_d = cnt_q + {2'd0, accept} - {2'd0, data_ret};
        drop_cnt_d = drop_cnt_q;
        if (flush)             drop_cnt_d = cnt_d;
        else if (data_ok_drop) drop_cnt_d = drop_cnt_q - 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            load_q     <= 1'b0;
            store_q    <= 1'b0;
            size_q     <= 2'd0;
            vaddr_q    <= 32'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 3'd0;
            drop_cnt_q <= 3'd0;
        end else begin
            valid_q    <= valid_d;
            load_q     <= load_d;
            store_q    <= store_d;
            size_q     <= size_d;
            vaddr_q    <= vaddr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_xlate_issue.sv
// Bench for mem_xlate_issue: constant vector table, randomized ops against a
// rule-level model, and hand sequences for outstanding limit, flush and reset.
module tb_mem_xlate_issue;
    localparam int NUM_DMW     = 2;
    localparam int OUTSTANDING = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_valid, in_allowin, in_load, in_store;
    logic [1:0] in_size;
    logic [31:0] in_vaddr, in_wdata;
    logic out_valid, out_allowin, out_mem_req, flush, direct_addr;
    logic [2:0] out_exc;
    logic [31:0] out_vaddr;
    logic [1:0] crmd_plv;
    logic [3*NUM_DMW-1:0] dmw_vseg, dmw_pseg;
    logic [NUM_DMW-1:0] dmw_plv0, dmw_plv3;
    logic [18:0] tlb_vppn;
    logic tlb_va_bit12, tlb_found, tlb_v, tlb_d;
    logic [19:0] tlb_ppn;
    logic [5:0] tlb_ps;
    logic [1:0] tlb_plv;
    logic data_req, data_wr, data_addr_ok, data_data_ok, data_ok_drop;
    logic [1:0] data_size;
    logic [3:0] data_wstrb;
    logic [31:0] data_addr, data_wdata;

    logic [2:0] win_vseg [NUM_DMW];
    logic [2:0] win_pseg [NUM_DMW];
    logic       win_plv0 [NUM_DMW];
    logic       win_plv3 [NUM_DMW];

    for (genvar g = 0; g < NUM_DMW; g++) begin : g_w
        assign dmw_vseg[3*g +: 3] = win_vseg[g];
        assign dmw_pseg[3*g +: 3] = win_pseg[g];
        assign dmw_plv0[g]        = win_plv0[g];
        assign dmw_plv3[g]        = win_plv3[g];
    end

    mem_xlate_issue #(.NUM_DMW(NUM_DMW), .OUTSTANDING(OUTSTANDING)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin),
        .in_load(in_load), .in_store(in_store), .in_size(in_size),
        .in_vaddr(in_vaddr), .in_wdata(in_wdata), .out_valid(out_valid),
        .out_allowin(out_allowin), .out_exc(out_exc), .out_vaddr(out_vaddr),
        .out_mem_req(out_mem_req), .flush(flush), .crmd_plv(crmd_plv),
        .direct_addr(direct_addr), .dmw_vseg(dmw_vseg), .dmw_pseg(dmw_pseg),
        .dmw_plv0(dmw_plv0), .dmw_plv3(dmw_plv3), .tlb_vppn(tlb_vppn),
        .tlb_va_bit12(tlb_va_bit12), .tlb_found(tlb_found), .tlb_v(tlb_v),
        .tlb_d(tlb_d), .tlb_ppn(tlb_ppn), .tlb_ps(tlb_ps), .tlb_plv(tlb_plv),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_ok_drop(data_ok_drop)
    );

    typedef struct {
        logic [2:0]  exc;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic [31:0] va;
        logic [31:0] wd;
        logic [1:0]  plv;
        logic        dir;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] exc, input logic [31:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata);
        exp_t e;
        e.exc = exc; e.req = (exc == 3'd0); e.addr = addr; e.wstrb = wstrb; e.wdata = wdata;
        return e;
    endfunction

    // Reference: derived from the translation and exception rules as plain arithmetic.
    function automatic exp_t model(input logic ld, input logic st, input logic [1:0] sz,
                                   input logic [31:0] va, input logic [31:0] wd,
                                   input logic [1:0] plv, input logic dir);
        exp_t e;
        int hit = -1;
        int unsigned bytes = 1 << sz;
        for (int i = 0; i < NUM_DMW; i++)
            if (hit < 0 && (va >> 29) == win_vseg[i] &&
                ((plv == 0 && win_plv0[i]) || (plv == 3 && win_plv3[i])))
                hit = i;
        if (dir)          e.addr = va;
        else if (hit >= 0) e.addr = (32'(win_pseg[hit]) << 29) | (va % 32'h20000000);
        else begin
`ifdef MEM_XLATE_TLB_EN
            if (tlb_ps == 22) e.addr = ((32'(tlb_ppn) >> 10) << 22) | (va % 32'h400000);
            else              e.addr = (32'(tlb_ppn) << 12) | (va % 4096);
`else
            e.addr = va;
`endif
        end
        e.exc = 0;
        if (!(ld || st))                          e.exc = 0;
        else if (va % bytes != 0)                 e.exc = 1;
        else if (va >= 32'h80000000 && plv == 3 && hit < 0 && !dir) e.exc = 2;
`ifdef MEM_XLATE_TLB_EN
        else if (hit < 0 && !dir) begin
            if (!tlb_found)          e.exc = 3;
            else if (!tlb_v)         e.exc = ld ? 4 : 5;
            else if (plv > tlb_plv)  e.exc = 6;
            else if (st && !tlb_d)   e.exc = 7;
        end
`endif
        e.req   = (ld || st) && e.exc == 0;
        e.wstrb = !st ? 4'd0 : (sz == 0) ? 4'(1 << (va % 4)) : (sz == 1) ? 4'(3 << (va % 4)) : 4'd15;
        e.wdata = (sz == 0) ? (wd % 256) * 32'h01010101 :
                  (sz == 1) ? (wd % 65536) * 32'h00010001 : wd;
        return e;
    endfunction

    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz,
                          input logic [31:0] va, input logic [31:0] wd, input logic [1:0] plv,
                          input logic dir, input exp_t e, input string tag);
        @(negedge clk);
        in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_vaddr = va; in_wdata = wd;
        crmd_plv = plv; direct_addr = dir; data_addr_ok = 1; out_allowin = 1;
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk);
        chk({tag, " exc"}, 32'(out_exc), 32'(e.exc));
        chk({tag, " req"}, 32'(data_req), 32'(e.req));
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " mem_req"}, 32'(out_mem_req), 32'(e.req));
        chk({tag, " vaddr"}, out_vaddr, va);
        if (e.req) begin
            chk({tag, " addr"}, data_addr, e.addr);
            chk({tag, " wr"}, 32'(data_wr), 32'(st));
            chk({tag, " wstrb"}, 32'(data_wstrb), 32'(e.wstrb));
            chk({tag, " size"}, 32'(data_size), 32'(sz));
            if (st) chk({tag, " wdata"}, data_wdata, e.wdata);
        end
        @(negedge clk); data_data_ok = e.req;
        @(negedge clk); data_data_ok = 0;
    endtask

    task automatic drive_ld(input logic [31:0] va);
        in_valid = 1; in_load = 1; in_store = 0; in_size = 2; in_vaddr = va; in_wdata = 0;
        direct_addr = 1; crmd_plv = 0;
    endtask

    // Issue two loads that get accepted and leave a third waiting on the limit.
    task automatic fill_three(input logic [31:0] base);
        @(negedge clk); data_addr_ok = 1; out_allowin = 1; drive_ld(base);
        @(negedge clk); drive_ld(base + 4);
        @(negedge clk); drive_ld(base + 8);
        @(negedge clk); in_valid = 0;
    endtask

    vec_t vt [10];

    initial begin
        reset = 1; in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_vaddr = 0;
        in_wdata = 0; out_allowin = 1; flush = 0; crmd_plv = 0; direct_addr = 0;
        tlb_found = 1; tlb_v = 1; tlb_d = 1; tlb_ppn = 20'hABCDE; tlb_ps = 22; tlb_plv = 3;
        data_addr_ok = 0; data_data_ok = 0;
        win_vseg[0] = 6; win_pseg[0] = 0; win_plv0[0] = 0; win_plv3[0] = 1;
        win_vseg[1] = 4; win_pseg[1] = 1; win_plv0[1] = 1; win_plv3[1] = 0;

        vt[0] = '{1, 0, 2, 32'h1C000010, 0, 0, 1, mk(0, 32'h1C000010, 4'h0, 0)};
        vt[1] = '{0, 1, 0, 32'h00000013, 32'h000000AB, 0, 1, mk(0, 32'h13, 4'h8, 32'hABABABAB)};
        vt[2] = '{0, 1, 1, 32'h00000022, 32'h00001234, 0, 1, mk(0, 32'h22, 4'hC, 32'h12341234)};
        vt[3] = '{0, 1, 0, 32'h00000100, 32'h00000055, 0, 1, mk(0, 32'h100, 4'h1, 32'h55555555)};
        vt[4] = '{1, 0, 2, 32'h00000002, 0, 0, 1, mk(1, 0, 0, 0)};
        vt[5] = '{0, 1, 1, 32'h00000001, 0, 0, 1, mk(1, 0, 0, 0)};
        vt[6] = '{1, 0, 2, 32'h90000000, 0, 3, 0, mk(2, 0, 0, 0)};
        vt[7] = '{1, 0, 2, 32'h80001234, 0, 0, 0, mk(0, 32'h20001234, 4'h0, 0)};
        vt[8] = '{0, 1, 2, 32'hC0000100, 32'hDEADBEEF, 3, 0, mk(0, 32'h00000100, 4'hF, 32'hDEADBEEF)};
`ifdef MEM_XLATE_TLB_EN
        vt[9] = '{1, 0, 2, 32'h00400008, 0, 0, 0, mk(0, 32'hABC00008, 4'h0, 0)};
`else
        vt[9] = '{1, 0, 2, 32'h00400008, 0, 0, 0, mk(0, 32'h00400008, 4'h0, 0)};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset allowin", 32'(in_allowin), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset req", 32'(data_req), 0);
        chk("reset exc", 32'(out_exc), 0);
        reset = 0;

        for (int i = 0; i < 10; i++)
            run_op(vt[i].ld, vt[i].st, vt[i].sz, vt[i].va, vt[i].wd, vt[i].plv, vt[i].dir,
                   vt[i].e, $sformatf("vec%0d", i));

`ifdef MEM_XLATE_TLB_EN
        tlb_found = 0;
        run_op(1, 0, 2, 32'h00001000, 0, 0, 0, mk(3, 0, 0, 0), "tlbr");
        tlb_found = 1; tlb_d = 0;
        run_op(0, 1, 2, 32'h00001000, 32'h1, 0, 0, mk(7, 0, 0, 0), "pme");
        tlb_d = 1;
`endif

        for (int n = 0; n < 60; n++) begin
            logic ld, st; logic [1:0] sz, plv; logic [31:0] va, wd; logic dir; int k;
            exp_t e;
            for (int w = 0; w < NUM_DMW; w++) begin
                win_vseg[w] = 3'($urandom_range(0, 7)); win_pseg[w] = 3'($urandom_range(0, 7));
                win_plv0[w] = 1'($urandom_range(0, 1)); win_plv3[w] = 1'($urandom_range(0, 1));
            end
            tlb_found = ($urandom_range(0, 5) != 0); tlb_v = ($urandom_range(0, 5) != 0);
            tlb_d = ($urandom_range(0, 3) != 0); tlb_ppn = 20'($urandom);
            tlb_ps = $urandom_range(0, 1) ? 6'd22 : 6'd12; tlb_plv = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            ld = (k < 5); st = (k >= 5 && k < 9);
            sz = 2'($urandom_range(0, 2));
            va = $urandom;
            if ($urandom_range(0, 3) != 0) va = va & ~(32'(1 << sz) - 1);
            wd = $urandom;
            k = $urandom_range(0, 2);
            plv = (k == 0) ? 2'd0 : (k == 1) ? 2'd3 : 2'd1;
            dir = ($urandom_range(0, 3) == 0);
            e = model(ld, st, sz, va, wd, plv, dir);
            run_op(ld, st, sz, va, wd, plv, dir, e, $sformatf("rnd%0d", n));
        end

        // addr_ok wait: request held stable, no handoff until accepted
        @(negedge clk); data_addr_ok = 0; out_allowin = 1; drive_ld(32'h00000200);
        @(negedge clk); in_valid = 0; #1;
        chk("wait req", 32'(data_req), 1);
        chk("wait out_valid", 32'(out_valid), 0);
        chk("wait allowin", 32'(in_allowin), 0);
        @(negedge clk);
        chk("wait addr hold", data_addr, 32'h00000200);
        data_addr_ok = 1; #1;
        chk("wait accept out_valid", 32'(out_valid), 1);
        @(negedge clk); data_data_ok = 1;
        @(negedge clk); data_data_ok = 0;

        // outstanding limit
        fill_three(32'h00001000);
        #1;
        chk("full req", 32'(data_req), 0);
        chk("full allowin", 32'(in_allowin), 0);
        chk("full out_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("full hold req", 32'(data_req), 0);
        data_data_ok = 1; #1;
        chk("full same-cycle req", 32'(data_req), 0);
        chk("full drop", 32'(data_ok_drop), 0);
        @(negedge clk); data_data_ok = 0; #1;
        chk("full next req", 32'(data_req), 1);
        chk("full next addr", data_addr, 32'h00001008);
        chk("full next out_valid", 32'(out_valid), 1);
        @(negedge clk); data_data_ok = 1;
        @(negedge clk);
        @(negedge clk); data_data_ok = 0;

        // flush with two in flight; a load offered in the flush cycle is refused
        fill_three(32'h00002000);
        flush = 1; drive_ld(32'h00003000); #1;
        chk("flush req", 32'(data_req), 0);
        @(negedge clk); flush = 0; in_valid = 0; #1;
        chk("flush cleared", 32'(out_valid), 0);
        chk("flush no accept", 32'(in_allowin), 1);
        data_data_ok = 1; #1;
        chk("drop 1", 32'(data_ok_drop), 1);
        @(negedge clk); #1;
        chk("drop 2", 32'(data_ok_drop), 1);
        @(negedge clk); data_data_ok = 0; drive_ld(32'h00004000);
        @(negedge clk); in_valid = 0; #1;
        chk("post-flush req", 32'(data_req), 1);
        @(negedge clk); data_data_ok = 1; #1;
        chk("post-flush no drop", 32'(data_ok_drop), 0);
        @(negedge clk); data_data_ok = 0;

        // reset while a request is waiting
        fill_three(32'h00005000);
        data_data_ok = 1; reset = 1; #1;
        chk("rst req", 32'(data_req), 0);
        chk("rst addr", data_addr, 0);
        chk("rst wstrb", 32'(data_wstrb), 0);
        chk("rst wr", 32'(data_wr), 0);
        chk("rst size", 32'(data_size), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst vaddr", out_vaddr, 0);
        chk("rst mem_req", 32'(out_mem_req), 0);
        chk("rst drop", 32'(data_ok_drop), 0);
        chk("rst allowin", 32'(in_allowin), 1);
        chk("rst tlb_vppn", 32'(tlb_vppn), 0);
        @(negedge clk); data_data_ok = 0; reset = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
